// File: rtl/mod_inv_engine.sv
// mod_inv_engine -- binary extended-Euclid modular inverter.
// Computes r = a^-1 mod q, fully reduced to [0, q-1]. Non-invertible, illegal
// or runaway inputs return err=1 with r=0. The request tag rides along with the
// result so the issuer can match responses.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      request handshake; ready only while IDLE
//   in_q, in_a, in_tag     modulus (odd, >=3), operand (0<a<q), opaque tag
//   out_valid/out_ready    response handshake; result held until accepted
//   out_r, out_err, out_tag  registered inverse, error flag, echoed tag
//   busy                   iteration in progress
module mod_inv_engine #(
  parameter int WIDTH = 384,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Hang guard only: a legal input always finishes well before this.
  localparam int CAP   = 4*WIDTH + 4;
  localparam int CNT_W = $clog2(CAP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] q_r, u, v, x1, x2;
  logic [CNT_W-1:0] cnt;

  // (x + q) / 2 for odd x written as (x>>1) + (q>>1) + 1 (both odd), which
  // avoids the WIDTH+1 intermediate; the result is < q so WIDTH bits suffice.
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] m);
    return x[0] ? (x >> 1) + (m >> 1) + WIDTH'(1) : (x >> 1);
  endfunction

  logic             accept, bad_in, step_done;
  logic [WIDTH:0]   d_uv, d_x1, d_x2;
  logic [WIDTH-1:0] x1_sub, x2_sub;

  assign accept = in_valid & (state == IDLE);
  assign bad_in = ~in_q[0] | (in_q < WIDTH'(3)) | (in_a == '0) | (in_a >= in_q);

  // Differences carry a borrow in bit WIDTH; a borrow means "add q back".
  assign d_uv   = {1'b0, u}  - {1'b0, v};
  assign d_x1   = {1'b0, x1} - {1'b0, x2};
  assign d_x2   = {1'b0, x2} - {1'b0, x1};
  assign x1_sub = d_x1[WIDTH] ? d_x1[WIDTH-1:0] + q_r : d_x1[WIDTH-1:0];
  assign x2_sub = d_x2[WIDTH] ? d_x2[WIDTH-1:0] + q_r : d_x2[WIDTH-1:0];

  assign step_done = (u == WIDTH'(1)) | (v == WIDTH'(1)) | (u == '0) | (v == '0) |
                     (cnt == CNT_W'(CAP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = bad_in ? DONE : RUN;
      RUN:  if (step_done) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0; u <= '0; v <= '0; x1 <= '0; x2 <= '0; cnt <= '0;
      out_r <= '0; out_err <= 1'b0; out_tag <= '0;
    end else if (accept) begin
      q_r     <= in_q;
      u       <= in_a;
      v       <= in_q;
      x1      <= WIDTH'(1);
      x2      <= '0;
      cnt     <= '0;
      out_tag <= in_tag;
      out_r   <= '0;
      out_err <= bad_in;
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      if (u == WIDTH'(1)) begin
        out_r <= x1;
      end else if (v == WIDTH'(1)) begin
        out_r <= x2;
      end else if ((u == '0) | (v == '0) | (cnt == CNT_W'(CAP))) begin
        out_r   <= '0;
        out_err <= 1'b1;
      end else if (~u[0]) begin
        u  <= u >> 1;
        x1 <= halve(x1, q_r);
      end else if (~v[0]) begin
        v  <= v >> 1;
        x2 <= halve(x2, q_r);
      end else if (~d_uv[WIDTH]) begin
        u  <= d_uv[WIDTH-1:0];
        x1 <= x1_sub;
      end else begin
        v  <= v - u;
        x2 <= x2_sub;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_mod_inv_engine.sv
// Directed bench for mod_inv_engine at WIDTH=32. Expected values are
// hand-computed constants, plus a product check r*a mod q == 1 for a short
// sweep over known 32-bit primes.
module tb_mod_inv_engine;
  localparam int W     = 32;
  localparam int TW    = 8;
  localparam int LMAX  = 4*W + 4 + 1;   // max acceptance-to-valid latency
  localparam int TMO   = 400;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [W-1:0]  in_q, in_a, out_r;
  logic [TW-1:0] in_tag, out_tag;

  int errors = 0;
  int checks = 0;

  mod_inv_engine #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_q(in_q), .in_a(in_a), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_err(out_err), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request, wait for acceptance, then count cycles to out_valid.
  // lat = 1 means out_valid is visible in the cycle right after acceptance.
  // Inputs are scrambled after acceptance to show they are not re-sampled.
  task automatic send(input logic [W-1:0] q, input logic [W-1:0] a,
                      input logic [TW-1:0] tag, output int lat);
    int n;
    in_q = q; in_a = a; in_tag = tag; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_q = '1; in_a = 32'h1234_5678; in_tag = 8'hEE;
    lat = 1;
    while (!out_valid && lat < TMO) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_q = '0; in_a = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready  !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_r     !== '0)   begin errors++; $display("FAIL reset_out_r got=%h exp=0", out_r); end
    if (out_err   !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    if (out_tag   !== '0)   begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    if (busy      !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    send(32'd13, 32'd5, 8'h5A, lat);
    checks += 4;
    if (out_r   !== 32'd8)  begin errors++; $display("FAIL basic_r got=%0d exp=8", out_r); end
    if (out_err !== 1'b0)   begin errors++; $display("FAIL basic_err got=%b exp=0", out_err); end
    if (out_tag !== 8'h5A)  begin errors++; $display("FAIL basic_tag got=%h exp=5a", out_tag); end
    if (lat > LMAX)         begin errors++; $display("FAIL basic_latency got=%0d exp<=%0d", lat, LMAX); end
    take();
  endtask

  task automatic test_min_latency();
    int lat;
    send(32'd97, 32'd1, 8'h01, lat);
    checks += 3;
    if (out_r   !== 32'd1) begin errors++; $display("FAIL min_r got=%0d exp=1", out_r); end
    if (out_err !== 1'b0)  begin errors++; $display("FAIL min_err got=%b exp=0", out_err); end
    if (lat != 2)          begin errors++; $display("FAIL min_latency got=%0d exp=2", lat); end
    take();
  endtask

  task automatic test_half();
    int lat;
    send(32'h7FFF_FFFF, 32'd2, 8'h02, lat);
    checks += 3;
    if (out_r   !== 32'h4000_0000) begin errors++; $display("FAIL half_r got=%h exp=40000000", out_r); end
    if (out_err !== 1'b0)          begin errors++; $display("FAIL half_err got=%b exp=0", out_err); end
    if (lat > LMAX)                begin errors++; $display("FAIL half_latency got=%0d exp<=%0d", lat, LMAX); end
    take();
  endtask

  task automatic test_illegal();
    logic [W-1:0] qv [3] = '{32'd13, 32'd13, 32'd12};
    logic [W-1:0] av [3] = '{32'd0,  32'd13, 32'd5};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(qv[i], av[i], 8'(8'h30 + i), lat);
      checks += 4;
      if (out_err !== 1'b1) begin errors++; $display("FAIL illegal%0d_err got=%b exp=1", i, out_err); end
      if (out_r   !== '0)   begin errors++; $display("FAIL illegal%0d_r got=%h exp=0", i, out_r); end
      if (lat != 1)         begin errors++; $display("FAIL illegal%0d_latency got=%0d exp=1", i, lat); end
      if (out_tag !== 8'(8'h30 + i)) begin errors++; $display("FAIL illegal%0d_tag got=%h exp=%h", i, out_tag, 8'(8'h30 + i)); end
      take();
    end
  endtask

  task automatic test_noninvertible();
    int lat;
    // q=15, a=5: v 15->10->5, then u-v reaches 0 after 3 steps -> error.
    send(32'd15, 32'd5, 8'h0F, lat);
    checks += 3;
    if (out_err !== 1'b1) begin errors++; $display("FAIL noninv_err got=%b exp=1", out_err); end
    if (out_r   !== '0)   begin errors++; $display("FAIL noninv_r got=%h exp=0", out_r); end
    if (lat != 5)         begin errors++; $display("FAIL noninv_latency got=%0d exp=5", lat); end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    logic bad;
    send(32'd13, 32'd5, 8'h11, lat);
    bad = 1'b0;
    // A competing request during DONE must be ignored.
    in_valid = 1'b1; in_q = 32'd97; in_a = 32'd1; in_tag = 8'h99;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_r !== 32'd8 || out_tag !== 8'h11 ||
          out_err !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold got=unstable exp=stable r=%0d tag=%h", out_r, out_tag); end
    take();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    if (in_ready  !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  qv [3] = '{32'd13, 32'd7,  32'd11};
    logic [W-1:0]  av [3] = '{32'd2,  32'd3,  32'd10};
    logic [W-1:0]  rv [3] = '{32'd7,  32'd5,  32'd10};
    logic [TW-1:0] tv [3] = '{8'hA1,  8'hB2,  8'hC3};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(qv[i], av[i], tv[i], lat);
      checks += 2;
      if (out_tag !== tv[i]) begin errors++; $display("FAIL b2b%0d_tag got=%h exp=%h", i, out_tag, tv[i]); end
      if (out_r   !== rv[i]) begin errors++; $display("FAIL b2b%0d_r got=%0d exp=%0d", i, out_r, rv[i]); end
      take();
    end
  endtask

  task automatic test_rst_mid_run();
    int lat;
    logic seen;
    in_q = 32'h7FFF_FFFF; in_a = 32'd3; in_tag = 8'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got=%b exp=1", busy); end
    rst = 1'b1; #1;
    checks += 3;
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", in_ready); end
    if (out_tag !== '0)    begin errors++; $display("FAIL rst_tag_after got=%h exp=0", out_tag); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2*LMAX; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_no_result got=valid exp=none"); end
    send(32'h7FFF_FFFF, 32'd3, 8'h78, lat);
    checks += 3;
    if (out_r   !== 32'h5555_5555) begin errors++; $display("FAIL rst_after_r got=%h exp=55555555", out_r); end
    if (out_err !== 1'b0)          begin errors++; $display("FAIL rst_after_err got=%b exp=0", out_err); end
    if (out_tag !== 8'h78)         begin errors++; $display("FAIL rst_after_tag got=%h exp=78", out_tag); end
    take();
  endtask

  task automatic test_sweep();
    longint unsigned primes [4] = '{64'd65521, 64'd1000003, 64'd2147483647, 64'd4294967291};
    longint unsigned a, prod;
    int lat;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 6; k++) begin
        a = (longint'($urandom) % (primes[p] - 1)) + 1;
        send(W'(primes[p]), W'(a), 8'(p*16 + k), lat);
        prod = (longint'(out_r) * a) % primes[p];
        checks += 3;
        if (prod != 1 || out_r >= W'(primes[p]))
          begin errors++; $display("FAIL sweep_q%0d_a%0d got r=%0d exp r*a mod q=1", primes[p], a, out_r); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL sweep_err got=%b exp=0", out_err); end
        if (lat > LMAX)       begin errors++; $display("FAIL sweep_latency got=%0d exp<=%0d", lat, LMAX); end
        take();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_latency();
    test_half();
    test_illegal();
    test_noninvertible();
    test_backpressure();
    test_back_to_back();
    test_rst_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
